// File: rtl/card_shoe_arbiter.sv
// rtl/card_shoe_arbiter.sv - round-robin arbitrated finite card shoe fed by an LFSR
// Optional automatic penetration refill: CARD_SHOE_RESHUFFLE_EN
module card_shoe_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int DECKS         = 1,
    parameter int MAX_RETRY     = 4,
    parameter int PEN_THRESHOLD = 13
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3:0]                 rnd,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       shuffle,
    output logic [NUM_REQ-1:0]         ack,
    output logic [3:0]                 card,
    output logic [$clog2(NUM_REQ)-1:0] card_owner,
    output logic [7:0]                 cards_left,
    output logic                       shoe_empty,
    output logic                       busy,
    output logic                       reshuffled
);

    localparam int         OWN_W     = $clog2(NUM_REQ);
    localparam int         RTY_W     = $clog2(MAX_RETRY + 1);
    localparam logic [4:0] RANK_FILL = 5'(4 * DECKS);
    localparam logic [7:0] SHOE_FILL = 8'(52 * DECKS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_SCAN,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [4:0]         r_cnt     [13];
    logic [4:0]         w_cnt_nxt [13];
    logic [7:0]         r_left;
    logic [7:0]         w_left_nxt;
    logic [OWN_W-1:0]   r_rr;
    logic [OWN_W-1:0]   w_rr_nxt;
    logic [OWN_W-1:0]   r_grant;
    logic [OWN_W-1:0]   w_grant_nxt;
    logic [OWN_W-1:0]   r_owner;
    logic [OWN_W-1:0]   w_owner_nxt;
    logic [OWN_W-1:0]   w_gnt_idx;
    logic [OWN_W-1:0]   w_cand;
    logic [RTY_W-1:0]   r_retry;
    logic [RTY_W-1:0]   w_retry_nxt;
    logic [RTY_W-1:0]   w_retry_inc;
    logic [3:0]         r_scan;
    logic [3:0]         w_scan_nxt;
    logic [3:0]         r_card;
    logic [3:0]         w_card_nxt;
    logic [3:0]         w_take_rank;
    logic [3:0]         w_rnd_idx;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] w_ack_nxt;
    logic               r_pend;
    logic               w_pend_nxt;
    logic               r_resh;
    logic               w_resh_nxt;
    logic               w_gnt_found;
    logic               w_rnd_valid;
    logic               w_rnd_avail;
    logic               w_scan_avail;
    logic               w_refill;
    logic               w_take;

    assign w_rnd_valid  = (rnd != 4'd0) && (rnd <= 4'd13);
    assign w_rnd_idx    = rnd - 4'd1;
    assign w_rnd_avail  = w_rnd_valid && (r_cnt[w_rnd_idx] != 5'd0);
    assign w_scan_avail = (r_cnt[r_scan - 4'd1] != 5'd0);
    assign w_retry_inc  = r_retry + RTY_W'(1);

`ifdef CARD_SHOE_RESHUFFLE_EN
    assign w_refill = r_pend | shuffle | (r_left < 8'(PEN_THRESHOLD));
`else
    logic [7:0] w_unused_pen;
    assign w_unused_pen = 8'(PEN_THRESHOLD);
    assign w_refill     = r_pend | shuffle;
`endif

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = OWN_W'((int'(r_rr) + i) % NUM_REQ);
            if (!w_gnt_found && req[w_cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_left_nxt  = r_left;
        w_rr_nxt    = r_rr;
        w_retry_nxt = r_retry;
        w_scan_nxt  = r_scan;
        w_grant_nxt = r_grant;
        w_pend_nxt  = r_pend | shuffle;
        w_ack_nxt   = '0;
        w_card_nxt  = r_card;
        w_owner_nxt = r_owner;
        w_resh_nxt  = 1'b0;
        w_take      = 1'b0;
        w_take_rank = rnd;

        case (r_state)
            S_IDLE: begin
                if (w_refill) begin
                    for (int k = 0; k < 13; k++) begin
                        w_cnt_nxt[k] = RANK_FILL;
                    end
                    w_left_nxt = SHOE_FILL;
                    w_resh_nxt = 1'b1;
                    w_pend_nxt = 1'b0;
                end else if (w_gnt_found && (r_left != 8'd0)) begin
                    w_grant_nxt = w_gnt_idx;
                    w_state_nxt = S_DRAW;
                end
            end
            S_DRAW: begin
                if (w_rnd_avail) begin
                    w_take      = 1'b1;
                    w_take_rank = rnd;
                end else begin
                    w_retry_nxt = w_retry_inc;
                    if (w_retry_inc >= RTY_W'(MAX_RETRY)) begin
                        w_state_nxt = S_SCAN;
                        w_scan_nxt  = w_rnd_valid ? rnd : 4'd1;
                    end
                end
            end
            S_SCAN: begin
                // Shoe is non-empty here, so this finds a rank within 13 steps.
                if (w_scan_avail) begin
                    w_take      = 1'b1;
                    w_take_rank = r_scan;
                end else begin
                    w_scan_nxt = (r_scan == 4'd13) ? 4'd1 : r_scan + 4'd1;
                end
            end
            S_RESP: begin
                w_rr_nxt    = (r_grant == OWN_W'(NUM_REQ - 1)) ? '0 : r_grant + OWN_W'(1);
                w_retry_nxt = '0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_take) begin
            w_cnt_nxt[w_take_rank - 4'd1] = r_cnt[w_take_rank - 4'd1] - 5'd1;
            w_left_nxt  = r_left - 8'd1;
            w_card_nxt  = w_take_rank;
            w_owner_nxt = r_grant;
            w_ack_nxt   = NUM_REQ'(1) << r_grant;
            w_state_nxt = S_RESP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            for (int k = 0; k < 13; k++) begin
                r_cnt[k] <= RANK_FILL;
            end
            r_left  <= SHOE_FILL;
            r_rr    <= '0;
            r_retry <= '0;
            r_scan  <= 4'd1;
            r_grant <= '0;
            r_pend  <= 1'b0;
            r_ack   <= '0;
            r_card  <= 4'd0;
            r_owner <= '0;
            r_resh  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_left  <= w_left_nxt;
            r_rr    <= w_rr_nxt;
            r_retry <= w_retry_nxt;
            r_scan  <= w_scan_nxt;
            r_grant <= w_grant_nxt;
            r_pend  <= w_pend_nxt;
            r_ack   <= w_ack_nxt;
            r_card  <= w_card_nxt;
            r_owner <= w_owner_nxt;
            r_resh  <= w_resh_nxt;
        end
    end

    assign ack        = r_ack;
    assign card       = r_card;
    assign card_owner = r_owner;
    assign cards_left = r_left;
    assign shoe_empty = (r_left == 8'd0);
    assign busy       = (r_state != S_IDLE);
    assign reshuffled = r_resh;

endmodule
